// File: rtl/dot_product_sequencer.sv
// Sequencer that loads an 8-pair operand buffer, clears and streams it into the dot-product MAC, and returns the result on a valid/ready port.
// Optional DP_CHAIN_EN: a start accepted together with the result handshake goes straight to CLEAR.
module dot_product_sequencer #(
  parameter int unsigned N_ELEM       = 8,
  parameter int unsigned DONE_TIMEOUT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [3:0]  wr_a,
  input  logic [3:0]  wr_b,
  input  logic        start,
  output logic        busy,
  output logic        err,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        mac_rst,
  output logic        mac_en,
  output logic [3:0]  mac_a,
  output logic [3:0]  mac_b,
  input  logic        mac_done,
  input  logic [15:0] mac_result
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned RES_W = 16;
  localparam int unsigned TMO_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   res_valid_q, res_valid_d;
  logic [RES_W-1:0]       res_data_q, res_data_d;
  logic                   mac_rst_q, mac_rst_d;
  logic                   mac_en_q, mac_en_d;
  logic [OP_W-1:0]        mac_a_q, mac_a_d;
  logic [OP_W-1:0]        mac_b_q, mac_b_d;
  logic [2*OP_W-1:0]      opbuf_q [N_ELEM];
  logic [2*OP_W-1:0]      opbuf_d [N_ELEM];
  logic                   wr_ok;
  logic [IDX_W-1:0]       idx_nxt;

  assign idx_nxt = idx_q + IDX_W'(1);

  // Next-state, registered-output and buffer-write logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    mac_rst_d   = 1'b0;
    mac_en_d    = 1'b0;
    mac_a_d     = '0;
    mac_b_d     = '0;
    opbuf_d     = opbuf_q;
    wr_ok       = 1'b0;

    case (state_q)
      S_IDLE: begin
        wr_ok = 1'b1;
        if (start) begin
          state_d   = S_CLEAR;
          err_d     = 1'b0;
          mac_rst_d = 1'b1;
        end
      end
      // Element 0 is fetched here so mac_en rises the first RUN cycle
      S_CLEAR: begin
        idx_d              = '0;
        mac_en_d           = 1'b1;
        {mac_a_d, mac_b_d} = opbuf_q[0];
        state_d            = S_RUN;
      end
      S_RUN: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end else begin
          idx_d              = idx_nxt;
          mac_en_d           = 1'b1;
          {mac_a_d, mac_b_d} = opbuf_q[idx_nxt];
        end
      end
      S_WAIT: begin
        if (mac_done) begin
          res_data_d  = mac_result;
          res_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_HOLD: begin
        wr_ok = 1'b1;
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
`ifdef DP_CHAIN_EN
          if (start) begin
            state_d   = S_CLEAR;
            err_d     = 1'b0;
            mac_rst_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_ok && wr_en) begin
      opbuf_d[wr_addr] = {wr_a, wr_b};
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      mac_rst_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      mac_rst_q   <= mac_rst_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
    end
  end

  // Operand storage has no reset
  always_ff @(posedge CLK) begin
    opbuf_q <= opbuf_d;
  end

  assign busy      = busy_q;
  assign err       = err_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign mac_rst   = mac_rst_q;
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Randomized self-checking bench for dot_product_sequencer with a behavioural MAC and a reference dot-product model.
module tb_dot_product_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_a;
  logic [3:0]  wr_b;
  logic        start;
  logic        busy;
  logic        err;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        mac_rst;
  logic        mac_en;
  logic [3:0]  mac_a;
  logic [3:0]  mac_b;
  logic        mac_done;
  logic [15:0] mac_result;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned ref_a [8];
  int unsigned ref_b [8];
  logic        kill_done = 1'b0;

  // Behavioural MAC: accumulates on enable, flags done after the 8th element
  logic [15:0] macc;
  logic [2:0]  mcnt;
  logic        mdone;

  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      macc <= '0; mcnt <= '0; mdone <= 1'b0;
    end else if (mac_rst) begin
      macc <= '0; mcnt <= '0; mdone <= 1'b0;
    end else begin
      mdone <= mac_en && (mcnt == 3'd7);
      if (mac_en) begin
        macc <= macc + 16'(mac_a) * 16'(mac_b);
        mcnt <= mcnt + 3'd1;
      end
    end
  end

  assign mac_done   = mdone & ~kill_done;
  assign mac_result = macc;

  dot_product_sequencer dut (
    .CLK(CLK), .RESET(RESET),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
    .start(start), .busy(busy), .err(err),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .mac_rst(mac_rst), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .mac_result(mac_result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int unsigned dot();
    int unsigned s = 0;
    for (int i = 0; i < 8; i++) s += ref_a[i] * ref_b[i];
    return s;
  endfunction

  // Single write while the sequencer is idle
  task automatic write_elem(input int unsigned addr, input int unsigned a, input int unsigned b);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_a = 4'(a); wr_b = 4'(b);
    tick();
    wr_en = 1'b0;
    ref_a[addr] = a; ref_b[addr] = b;
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) write_elem(i, $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_err"}, 32'(err), 0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 0);
    check_eq({tag, "_res_data"}, 32'(res_data), 0);
    check_eq({tag, "_mac_rst"}, 32'(mac_rst), 0);
    check_eq({tag, "_mac_en"}, 32'(mac_en), 0);
    check_eq({tag, "_mac_a"}, 32'(mac_a), 0);
    check_eq({tag, "_mac_b"}, 32'(mac_b), 0);
  endtask

  // Full run: optional write attempt during RUN at mid_cyc, optional stall in HOLD with write+start
  task automatic do_run(input string tag, input int mid_cyc, input int hold_cyc, input int unsigned hold_addr);
    int unsigned exp;
    int unsigned ha, hb;
    int cyc;
    exp = dot();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check_eq({tag, "_mac_rst"}, 32'(mac_rst), 1);
    check_eq({tag, "_err_clr"}, 32'(err), 0);
    while (!res_valid && cyc < 40) begin
      check_eq({tag, "_busy"}, 32'(busy), 1);
      check_eq({tag, "_mac_en"}, 32'(mac_en), 32'(cyc >= 2 && cyc <= 9));
      if (cyc >= 2 && cyc <= 9) begin
        check_eq({tag, "_mac_a"}, 32'(mac_a), ref_a[cyc-2]);
        check_eq({tag, "_mac_b"}, 32'(mac_b), ref_b[cyc-2]);
      end
      wr_en = (cyc == mid_cyc);
      wr_addr = 3'd3; wr_a = 4'(~ref_a[3]); wr_b = 4'(~ref_b[3] + 1);
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    check_eq({tag, "_latency"}, cyc, 11);
    check_eq({tag, "_res_data"}, 32'(res_data), exp);
    check_eq({tag, "_busy_hold"}, 32'(busy), 1);
    ha = $urandom_range(0, 15); hb = $urandom_range(0, 15);
    for (int k = 0; k < hold_cyc; k++) begin
      res_ready = 1'b0; start = 1'b1; wr_en = 1'b1;
      wr_addr = 3'(hold_addr); wr_a = 4'(ha); wr_b = 4'(hb);
      tick();
      check_eq({tag, "_hold_valid"}, 32'(res_valid), 1);
      check_eq({tag, "_hold_data"}, 32'(res_data), exp);
    end
    start = 1'b0; wr_en = 1'b0;
    if (hold_cyc > 0) begin
      ref_a[hold_addr] = ha; ref_b[hold_addr] = hb;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(res_valid), 0);
    check_eq({tag, "_busy_idle"}, 32'(busy), 0);
    check_eq({tag, "_mac_rst_idle"}, 32'(mac_rst), 0);
  endtask

  initial begin
    int cyc;
    bit saw_valid;
    int unsigned exp;
    RESET = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
    start = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin ref_a[i] = 0; ref_b[i] = 0; end
    tick(); tick();
    check_reset_outputs("rst");
    RESET = 1'b0;
    tick();

    // A = 1..8, B = 1 -> 36
    for (int i = 0; i < 8; i++) write_elem(i, i + 1, 1);
    check_eq("model36", dot(), 36);
    do_run("seq36", 0, 0, 0);

    // Maximum sum then a small one: MAC must be cleared between runs
    for (int i = 0; i < 8; i++) write_elem(i, 15, 15);
    do_run("max", 0, 0, 0);
    for (int i = 0; i < 8; i++) write_elem(i, 1, 2);
    do_run("after_max", 0, 0, 0);

    // Stall in HOLD with write+start; write lands, start ignored
    load_random();
    do_run("hold", 0, 5, 5);
    do_run("hold_wr_used", 0, 0, 0);

    // Write during RUN is ignored
    load_random();
    do_run("run_wr", 4, 0, 0);
    do_run("run_wr_again", 0, 0, 0);

    // mac_done never arrives: timeout after 4 WAIT cycles
    kill_done = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    saw_valid = 1'b0;
    while (!err && cyc < 40) begin
      if (res_valid) saw_valid = 1'b1;
      tick();
      cyc++;
    end
    check_eq("tmo_cycle", cyc, 14);
    check_eq("tmo_no_valid", 32'(saw_valid | res_valid), 0);
    check_eq("tmo_idle", 32'(busy), 0);
    kill_done = 1'b0;
    tick();
    check_eq("tmo_sticky", 32'(err), 1);
    do_run("after_tmo", 0, 0, 0);

    // Reset mid-run at idx 4
    load_random();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    check_eq("mid_mac_a", 32'(mac_a), ref_a[4]);
    RESET = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    RESET = 1'b0;
    tick();
    do_run("after_rst", 0, 0, 0);

    // Random runs
    for (int r = 0; r < 4; r++) begin
      load_random();
      do_run("rand", 0, 0, 0);
    end

    // Start coincident with result handshake
    load_random();
    exp = dot();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!res_valid && cyc < 40) begin tick(); cyc++; end
    check_eq("chain_first", 32'(res_data), exp);
    start = 1'b1; res_ready = 1'b1;
    tick();
    start = 1'b0; res_ready = 1'b0;
`ifdef DP_CHAIN_EN
    check_eq("chain_mac_rst", 32'(mac_rst), 1);
    check_eq("chain_busy", 32'(busy), 1);
    check_eq("chain_valid", 32'(res_valid), 0);
    cyc = 1;
    while (!res_valid && cyc < 40) begin tick(); cyc++; end
    check_eq("chain_latency", cyc, 11);
    check_eq("chain_second", 32'(res_data), exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("chain_end", 32'(busy), 0);
`else
    check_eq("nochain_mac_rst", 32'(mac_rst), 0);
    check_eq("nochain_busy", 32'(busy), 0);
    check_eq("nochain_valid", 32'(res_valid), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
Controller that owns the 8-element 4-bit dot-product MAC unit.
- Buffers two 8-entry operand vectors loaded by a host.
- On a start request, clears the MAC, streams the 8 element pairs into it, captures the 16-bit result, and presents it on a valid/ready result port.
- Sits between the host register interface and the MAC.
- Guarantees the MAC is always cleared before a run; the MAC's 3-bit element counter wraps, so a MAC that is not cleared would keep accumulating.

Parameters:
N_ELEM, 8, number of element pairs per run; fixed to match the MAC, do not override
DONE_TIMEOUT, 4, maximum WAIT cycles for mac_done before an error abort

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
wr_en  input  1  operand buffer write strobe
wr_addr  input  3  element index to write
wr_a  input  4  vector A element
wr_b  input  4  vector B element
start  input  1  request a dot-product run
busy  output  1  high in every state except IDLE
err  output  1  sticky timeout flag; cleared when the next start is accepted
res_valid  output  1  result available
res_ready  input  1  host accepts result
res_data  output  16  captured dot product
mac_rst  output  1  registered clear pulse to the MAC reset input
mac_en  output  1  registered MAC enable
mac_a  output  4  registered element A to the MAC
mac_b  output  4  registered element B to the MAC
mac_done  input  1  MAC DONE
mac_result  input  16  MAC result

Behaviour:
- Reset values: busy=0, err=0, res_valid=0, res_data=0, mac_rst=0, mac_en=0, mac_a=0, mac_b=0, state=IDLE, idx=0, timeout counter=0. Buffer contents are not reset.
- Operand buffer: 8 entries x (4+4) bits. A write on wr_en is accepted only in IDLE or HOLD. wr_en in CLEAR/RUN/WAIT is silently ignored, so the buffer is stable during a run.
- IDLE: start=1 -> CLEAR, err<=0. Start in any other state is ignored (except under DP_CHAIN_EN).
- CLEAR: exactly one cycle with mac_rst=1; idx<=0; -> RUN.
- RUN: 8 consecutive cycles with mac_en=1 and mac_a/mac_b = buffer[idx], idx = 0..7. After idx=7 is issued -> WAIT; mac_en=0 and mac_a=mac_b=0 outside RUN.
- WAIT: count cycles.
  - mac_done=1 -> res_data<=mac_result, res_valid<=1, -> HOLD.
  - DONE_TIMEOUT cycles without mac_done -> err<=1, -> IDLE, res_valid stays 0.
- HOLD: res_valid=1; res_data stable until handshake. res_valid & res_ready -> res_valid<=0, -> IDLE.
- Latency: start sampled at edge 0 -> mac_rst high in cycle 1 -> mac_en high in cycles 2..9 -> mac_done sampled in cycle 10 -> res_valid high from cycle 11. Minimum 11 cycles from start to res_valid.
- Width rules: products are 8 bits, sums 16 bits; maximum result 8*225=1800, so no overflow is possible and no saturation is applied.
- Simultaneous wr_en and start in IDLE: the write completes and the start is accepted. The run uses the new value, because the buffer read happens in RUN.
- RESET mid-run: immediate return to IDLE with all outputs at reset values, and any pending result is lost. The MAC is reset by the same global RESET at the top level.

Optional Feature:
DP_CHAIN_EN
- Defined: in HOLD, start=1 in the same cycle as res_valid & res_ready goes directly to CLEAR, enabling back-to-back runs with no IDLE cycle. err is cleared as on a normal start.
- Not defined: start in HOLD is ignored, and the FSM always passes through IDLE.

Test Plan:
- Load A=1..8 and B=1 in every entry, start -> res_valid in cycle 11; res_data=0x0024 (36); busy is high for cycles 1..11 and low after the handshake.
- Load A=B=15 in every entry -> res_data=0x0708 (1800); a second run with A=1, B=2 in every entry -> 0x0010, proving the MAC was cleared between runs.
- Hold res_ready=0 for 5 cycles in HOLD while driving wr_en and start -> res_data stays stable; the write is accepted but the start is ignored. Release res_ready -> IDLE.
- Pulse wr_en with wr_addr=3 and a new value during RUN -> ignored; the result is unchanged from the expected sum of the original data.
- Tie mac_done=0 -> err=1 after 4 WAIT cycles, state IDLE, res_valid never asserted. The next start clears err.
- Assert RESET during RUN at idx=4 -> all outputs reach reset values asynchronously. A fresh start then produces the correct full result.
- With DP_CHAIN_EN, assert start together with the result handshake -> mac_rst is high the next cycle.
